// File: rtl/midi_pkg.sv
// rtl/midi_pkg.sv - shared types, constants and field packers for the MIDI event encoder
//
// Contents:
//   parser_state_t   : parser state encoding (IDLE, WAIT_D1, WAIT_D2, SYSEX)
//   status nibbles   : NOTE_OFF .. PITCH channel-message opcodes
//   SYSEX_START/END  : system-exclusive framing bytes
//   EV_VOICE/EV_ALL  : event type tag stored in the FIFO entry MSB
//   field offsets    : bit positions inside note_values / controller_values
//   pack_note/ctrl   : build 16-bit payloads from the field offsets
//   two_data_bytes   : message length lookup by status byte
package midi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT_D1 = 2'd1,
      ST_WAIT_D2 = 2'd2,
      ST_SYSEX   = 2'd3
   } parser_state_t;

   localparam logic [3:0] NOTE_OFF = 4'h8;
   localparam logic [3:0] NOTE_ON  = 4'h9;
   localparam logic [3:0] POLY_AT  = 4'hA;
   localparam logic [3:0] CC       = 4'hB;
   localparam logic [3:0] PROG     = 4'hC;
   localparam logic [3:0] CH_AT    = 4'hD;
   localparam logic [3:0] PITCH    = 4'hE;

   localparam logic [7:0] SYSEX_START = 8'hF0;
   localparam logic [7:0] SYSEX_END   = 8'hF7;
   localparam logic [7:0] SONG_POS    = 8'hF2;
   localparam logic [7:0] REALTIME_LO = 8'hF8;

   localparam logic EV_VOICE = 1'b0;
   localparam logic EV_ALL   = 1'b1;

   localparam int PAYLOAD_W    = 16;
   localparam int EVENT_W      = PAYLOAD_W + 1;
   localparam int KEY_ON_BIT   = 15;
   localparam int NOTE_IDX_LSB = 8;
   localparam int NOTE_IDX_W   = 6;
   localparam int VEL_LSB      = 0;
   localparam int CTRL_NUM_LSB = 8;
   localparam int CTRL_VAL_LSB = 0;
   localparam int DATA_W       = 7;

   function automatic logic [PAYLOAD_W-1:0] pack_note(
      input logic                  key_on,
      input logic [NOTE_IDX_W-1:0] idx,
      input logic [DATA_W-1:0]     vel
   );
      logic [PAYLOAD_W-1:0] v;
      v                            = '0;
      v[KEY_ON_BIT]                = key_on;
      v[NOTE_IDX_LSB +: NOTE_IDX_W] = idx;
      v[VEL_LSB +: DATA_W]         = vel;
      return v;
   endfunction

   function automatic logic [PAYLOAD_W-1:0] pack_ctrl(
      input logic [DATA_W-1:0] num,
      input logic [DATA_W-1:0] val
   );
      logic [PAYLOAD_W-1:0] v;
      v                         = '0;
      v[CTRL_NUM_LSB +: DATA_W] = num;
      v[CTRL_VAL_LSB +: DATA_W] = val;
      return v;
   endfunction

   // Song position is the only system-common message carrying two data bytes.
   function automatic logic two_data_bytes(input logic [7:0] status);
      logic r;
      r = 1'b0;
      if (status == SONG_POS) begin
         r = 1'b1;
      end else begin
         case (status[7:4])
            NOTE_OFF, NOTE_ON, POLY_AT, CC, PITCH: r = 1'b1;
            PROG, CH_AT:                           r = 1'b0;
            default:                               r = 1'b0;
         endcase
      end
      return r;
   endfunction

endpackage

// File: rtl/midi_event_fifo.sv
// rtl/midi_event_fifo.sv - parameterised synchronous FIFO with full/empty flags
//
// Ports:
//   clk, reset      : clock, asynchronous active-low reset (0 = reset)
//   wr_en, wr_data  : push request and entry; ignored when full unless a pop
//                     happens on the same edge
//   rd_en           : pop request; ignored when empty
//   rd_data         : head entry (valid whenever empty = 0)
//   full, empty     : occupancy flags
module midi_event_fifo #(
   parameter int WIDTH = 17,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   // One extra pointer bit separates the full and empty cases when the
   // index bits match.
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             wr_accept;
   logic             rd_accept;

   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rd_accept = rd_en && !empty;
   // A simultaneous pop frees the slot, so a push while full is still taken.
   assign wr_accept = wr_en && (!full || rd_accept);
   assign rd_data   = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_accept) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_accept) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem[wr_ptr[AW-1:0]] <= wr_data;
      end
   end

endmodule

// File: rtl/midi_event_encoder.sv
// rtl/midi_event_encoder.sv - MIDI byte stream to voice-control strobes and payloads
//
// Ports:
//   clk, reset         : clock, asynchronous active-low reset (0 = reset)
//   byte_valid/byte_in : one-cycle strobe with a received MIDI byte
//   generate_next      : sample-generation strobe; no event is issued while high
//   update_voice       : one-cycle strobe, note_values valid
//   update_all_voices  : one-cycle strobe, controller_values valid
//   note_values        : {key_on, 0, note index[5:0], 0, velocity[6:0]}
//   controller_values  : {0, controller[6:0], 0, value[6:0]}
//   overflow           : sticky, an event was dropped on a full FIFO
//   fifo_empty         : no pending events
//
// Build option:
//   MIDI_OMNI_EN       : when defined, every channel produces events and
//                        CHANNEL is ignored.
module midi_event_encoder #(
   parameter int CHANNEL    = 0,
   parameter int NOTE_BASE  = 36,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        byte_valid,
   input  logic [7:0]  byte_in,
   input  logic        generate_next,
   output logic        update_voice,
   output logic        update_all_voices,
   output logic [15:0] note_values,
   output logic [15:0] controller_values,
   output logic        overflow,
   output logic        fifo_empty
);

   import midi_pkg::*;

   localparam logic [7:0] BASE = 8'(NOTE_BASE);

   parser_state_t        state_q, state_d;
   logic [7:0]           status_q, status_d;
   logic [DATA_W-1:0]    d1_q, d1_d;

   logic                 is_realtime;
   logic                 sys_common;
   logic                 ch_ok;
   logic [7:0]           note_ext;
   logic [7:0]           note_rel;
   logic                 in_window;
   logic [DATA_W-1:0]    d2;

   logic                 push;
   logic [EVENT_W-1:0]   push_data;
   logic                 pop;
   logic [EVENT_W-1:0]   head;
   logic                 fifo_full;
   logic                 fifo_empty_w;

   assign is_realtime = (byte_in >= REALTIME_LO);
   // F1/F2/F3 reuse the data-byte states to swallow their payload, then
   // fall back to IDLE instead of staying under running status.
   assign sys_common  = (status_q[7:4] == 4'hF);
   assign d2          = byte_in[DATA_W-1:0];
   assign note_ext    = {1'b0, d1_q};
   assign note_rel    = note_ext - BASE;
   assign in_window   = (note_ext >= BASE) && (note_rel[7:6] == 2'b00);

`ifdef MIDI_OMNI_EN
   assign ch_ok = 1'b1;
`else
   assign ch_ok = (status_q[3:0] == CHANNEL[3:0]);
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         status_q <= '0;
         d1_q     <= '0;
      end else begin
         state_q  <= state_d;
         status_q <= status_d;
         d1_q     <= d1_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      status_d  = status_q;
      d1_d      = d1_q;
      push      = 1'b0;
      push_data = '0;

      if (byte_valid && !is_realtime) begin
         if (state_q == ST_SYSEX) begin
            if (byte_in == SYSEX_END) begin
               state_d = ST_IDLE;
            end
         end else if (byte_in[7]) begin
            if (byte_in < SYSEX_START) begin
               // New channel status aborts any partial message.
               status_d = byte_in;
               state_d  = ST_WAIT_D1;
            end else begin
               status_d = '0;
               case (byte_in)
                  SYSEX_START: state_d = ST_SYSEX;
                  8'hF1, 8'hF2, 8'hF3: begin
                     status_d = byte_in;
                     state_d  = ST_WAIT_D1;
                  end
                  default:     state_d = ST_IDLE;
               endcase
            end
         end else begin
            case (state_q)
               ST_WAIT_D1: begin
                  if (two_data_bytes(status_q)) begin
                     d1_d    = byte_in[DATA_W-1:0];
                     state_d = ST_WAIT_D2;
                  end else if (sys_common) begin
                     status_d = '0;
                     state_d  = ST_IDLE;
                  end
               end
               ST_WAIT_D2: begin
                  if (sys_common) begin
                     status_d = '0;
                     state_d  = ST_IDLE;
                  end else begin
                     state_d = ST_WAIT_D1;
                     if (ch_ok) begin
                        case (status_q[7:4])
                           NOTE_ON, NOTE_OFF: begin
                              if (in_window) begin
                                 push      = 1'b1;
                                 push_data = {EV_VOICE,
                                              pack_note((status_q[7:4] == NOTE_ON) && (d2 != '0),
                                                        note_rel[NOTE_IDX_W-1:0], d2)};
                              end
                           end
                           CC: begin
                              push      = 1'b1;
                              push_data = {EV_ALL, pack_ctrl(d1_q, d2)};
                           end
                           default: ;
                        endcase
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign pop = !fifo_empty_w && !generate_next;

   midi_event_fifo #(
      .WIDTH (EVENT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (push),
      .wr_data (push_data),
      .rd_en   (pop),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty_w)
   );

   assign fifo_empty = fifo_empty_w;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         update_voice      <= 1'b0;
         update_all_voices <= 1'b0;
         note_values       <= '0;
         controller_values <= '0;
         overflow          <= 1'b0;
      end else begin
         update_voice      <= 1'b0;
         update_all_voices <= 1'b0;
         if (pop) begin
            if (head[EVENT_W-1] == EV_ALL) begin
               update_all_voices <= 1'b1;
               controller_values <= head[PAYLOAD_W-1:0];
            end else begin
               update_voice <= 1'b1;
               note_values  <= head[PAYLOAD_W-1:0];
            end
         end
         if (push && fifo_full && !pop) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_midi_event_encoder.sv
// tb/tb_midi_event_encoder.sv - self-checking bench for midi_event_encoder
module tb_midi_event_encoder;

   localparam int NB    = 36;
   localparam int DEPTH = 4;
   localparam int CHAN  = 0;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_in = 8'h00;
   logic        generate_next = 1'b0;
   logic        update_voice;
   logic        update_all_voices;
   logic [15:0] note_values;
   logic [15:0] controller_values;
   logic        overflow;
   logic        fifo_empty;

   int checks = 0;
   int errors = 0;
   int n_uv = 0;
   int n_ua = 0;

   midi_event_encoder #(
      .CHANNEL    (CHAN),
      .NOTE_BASE  (NB),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .byte_valid        (byte_valid),
      .byte_in           (byte_in),
      .generate_next     (generate_next),
      .update_voice      (update_voice),
      .update_all_voices (update_all_voices),
      .note_values       (note_values),
      .controller_values (controller_values),
      .overflow          (overflow),
      .fifo_empty        (fifo_empty)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          m_rs;        // running status byte, -1 when none
   int          m_have;      // data bytes collected for the current message
   int          m_skip;      // system-common data bytes still to swallow
   bit          m_sysex;
   int          m_d[2];
   bit          m_pend;
   logic [16:0] m_ev;
   logic [16:0] mq[$];
   logic        exp_uv, exp_ua, exp_ovf, exp_empty;
   logic [15:0] exp_note, exp_ctrl;

   function automatic int msg_len(input int st);
      return ((st >> 4) == 12 || (st >> 4) == 13) ? 1 : 2;
   endfunction

   task automatic model_emit();
      int op, ch, note, vel, kon;
      op   = m_rs >> 4;
      ch   = m_rs & 15;
      note = m_d[0];
      vel  = m_d[1];
`ifndef MIDI_OMNI_EN
      if (ch != CHAN) return;
`endif
      if (op == 8 || op == 9) begin
         if (note >= NB && note <= NB + 63) begin
            kon    = (op == 9 && vel > 0) ? 1 : 0;
            m_pend = 1'b1;
            m_ev   = 17'(kon * 32768 + (note - NB) * 256 + vel);
         end
      end else if (op == 11) begin
         m_pend = 1'b1;
         m_ev   = 17'(65536 + note * 256 + vel);
      end
   endtask

   task automatic model_byte(input int b);
      if (b >= 'hF8) begin
      end else if (m_sysex) begin
         if (b == 'hF7) m_sysex = 1'b0;
      end else if (b >= 'h80 && b <= 'hEF) begin
         m_rs = b; m_have = 0; m_skip = 0;
      end else if (b == 'hF0) begin
         m_sysex = 1'b1; m_rs = -1; m_skip = 0;
      end else if (b == 'hF1 || b == 'hF3) begin
         m_rs = -1; m_skip = 1;
      end else if (b == 'hF2) begin
         m_rs = -1; m_skip = 2;
      end else if (b >= 'hF4) begin
         m_rs = -1; m_skip = 0;
      end else if (m_skip > 0) begin
         m_skip--;
      end else if (m_rs >= 0) begin
         m_d[m_have] = b;
         m_have++;
         if (m_have == msg_len(m_rs)) begin
            m_have = 0;
            model_emit();
         end
      end
   endtask

   always @(posedge clk or negedge reset) begin : model
      bit          do_pop;
      bit          was_full;
      logic [16:0] e;
      if (!reset) begin
         m_rs = -1; m_have = 0; m_skip = 0; m_sysex = 1'b0;
         mq.delete();
         exp_uv = 1'b0; exp_ua = 1'b0; exp_ovf = 1'b0; exp_empty = 1'b1;
         exp_note = 16'h0; exp_ctrl = 16'h0;
      end else begin
         do_pop   = (mq.size() > 0) && !generate_next;
         was_full = (mq.size() == DEPTH);
         m_pend   = 1'b0;
         if (byte_valid) model_byte(int'(byte_in));
         exp_uv = 1'b0;
         exp_ua = 1'b0;
         if (do_pop) begin
            e = mq.pop_front();
            if (e[16]) begin exp_ua = 1'b1; exp_ctrl = e[15:0]; end
            else       begin exp_uv = 1'b1; exp_note = e[15:0]; end
         end
         if (m_pend) begin
            if (was_full && !do_pop) exp_ovf = 1'b1;
            else mq.push_back(m_ev);
         end
         exp_empty = (mq.size() == 0);
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         check("update_voice", 32'(update_voice), 32'(exp_uv));
         check("update_all_voices", 32'(update_all_voices), 32'(exp_ua));
         check("note_values", 32'(note_values), 32'(exp_note));
         check("controller_values", 32'(controller_values), 32'(exp_ctrl));
         check("overflow", 32'(overflow), 32'(exp_ovf));
         check("fifo_empty", 32'(fifo_empty), 32'(exp_empty));
         if (update_voice) n_uv++;
         if (update_all_voices) n_ua++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic send(input logic [7:0] b);
      byte_in    = b;
      byte_valid = 1'b1;
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_uv"}, 32'(update_voice), 32'd0);
      check({tag, "_ua"}, 32'(update_all_voices), 32'd0);
      check({tag, "_note"}, 32'(note_values), 32'd0);
      check({tag, "_ctrl"}, 32'(controller_values), 32'd0);
      check({tag, "_ovf"}, 32'(overflow), 32'd0);
      check({tag, "_empty"}, 32'(fifo_empty), 32'd1);
   endtask

   int base;
   logic [7:0] burst[10];

   initial begin
      burst = '{8'h90, 8'h3C, 8'h01, 8'h3D, 8'h02, 8'h3E, 8'h03, 8'h3F, 8'h04, 8'h40};

      // reset state
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      #1 reset = 1'b1;
      @(negedge clk);

      // note on, latency and single-cycle strobe
      send(8'h90); send(8'h3C); send(8'h64);
      check("lat_not_early", 32'(update_voice), 32'd0);
      @(negedge clk);
      check("lat_strobe", 32'(update_voice), 32'd1);
      check("lat_note", 32'(note_values), 32'h9864);
      @(negedge clk);
      check("strobe_one_cycle", 32'(update_voice), 32'd0);

      // running status, note-on with velocity 0
      send(8'h3E); send(8'h00);
      @(negedge clk);
      check("rs_strobe", 32'(update_voice), 32'd1);
      check("rs_note", 32'(note_values), 32'h1A00);

      // controller with an embedded realtime byte
      base = n_ua;
      send(8'hB0); send(8'h40); send(8'hFE); send(8'h7F);
      @(negedge clk);
      check("cc_strobe", 32'(update_all_voices), 32'd1);
      check("cc_value", 32'(controller_values), 32'h407F);
      idle(3);
      check("cc_count", 32'(n_ua - base), 32'd1);

      // sysex clears running status; trailing data dropped
      base = n_uv + n_ua;
      send(8'hF0); send(8'h12); send(8'h34); send(8'hF7); send(8'h45); send(8'h10);
      idle(3);
      check("sysex_no_event", 32'(n_uv + n_ua - base), 32'd0);

      // channel filter
      base = n_uv;
      send(8'h91); send(8'h3C); send(8'h64);
      idle(3);
`ifdef MIDI_OMNI_EN
      check("chan_omni", 32'(n_uv - base), 32'd1);
`else
      check("chan_filter", 32'(n_uv - base), 32'd0);
`endif

      // note window boundaries
      base = n_uv;
      send(8'h90); send(8'h10); send(8'h40);
      send(8'h64); send(8'h01);
      send(8'h23); send(8'h05);
      send(8'h63); send(8'h7F);
      @(negedge clk);
      check("win_top_note", 32'(note_values), 32'hBF7F);
      idle(2);
      check("win_count", 32'(n_uv - base), 32'd1);
      check("win_no_ovf", 32'(overflow), 32'd0);
      send(8'h24); send(8'h11);
      @(negedge clk);
      check("win_bottom_note", 32'(note_values), 32'h8011);

      // note off keeps velocity
      send(8'h80); send(8'h3C); send(8'h55);
      @(negedge clk);
      check("note_off", 32'(note_values), 32'h1855);

      // overflow while generation blocks the output
      generate_next = 1'b1;
      for (int i = 0; i < 10; i++) send(burst[i]);
      send(8'h05);
      idle(2);
      check("ovf_set", 32'(overflow), 32'd1);
      check("ovf_not_empty", 32'(fifo_empty), 32'd0);
      check("ovf_blocked", 32'(update_voice), 32'd0);
      generate_next = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("drain_strobe", 32'(update_voice), 32'd1);
         check("drain_note", 32'(note_values), 32'(16'h9801 + 16'(i) * 16'h0101));
      end
      check("drain_empty", 32'(fifo_empty), 32'd1);
      @(negedge clk);
      check("drain_done", 32'(update_voice), 32'd0);

      // reset mid-message discards the partial message
      send(8'h90); send(8'h3C);
      #1 reset = 1'b0;
      @(negedge clk);
      check_reset_outputs("midreset");
      #1 reset = 1'b1;
      @(negedge clk);
      base = n_uv;
      send(8'h64);
      idle(3);
      check("midreset_no_event", 32'(n_uv - base), 32'd0);

      // push and pop on the same edge while full
      base = n_uv;
      generate_next = 1'b1;
      for (int i = 0; i < 10; i++) send(burst[i]);
      generate_next = 1'b0;
      send(8'h05);
      idle(8);
      check("fullpp_count", 32'(n_uv - base), 32'd5);
      check("fullpp_no_ovf", 32'(overflow), 32'd0);
      check("fullpp_last", 32'(note_values), 32'h9C05);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/midi_event_encoder.md
Name: midi_event_encoder

Overview:
Converts the raw MIDI byte stream from the UART receiver into the voice-control strobes and payloads that the harmonic dynamics engine consumes: update_voice with note_values, and update_all_voices with controller_values. Contains a MIDI status/running-status parser, a small event FIFO and an output stage. Events are issued only outside sample-generation cycles.

Parameters:
CHANNEL, 0, MIDI channel (0-15) accepted by the channel filter.
NOTE_BASE, 36, MIDI note number that maps to voice note index 0. The valid window is NOTE_BASE to NOTE_BASE+63.
FIFO_DEPTH, 4, event FIFO entries. Must be a power of two, at least 2.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset)
byte_valid  in  1  one-cycle strobe; byte_in is valid
byte_in  in  8  received MIDI byte
generate_next  in  1  sample-generation strobe; no event is issued while it is high
update_voice  out  1  one-cycle strobe; note_values is valid
update_all_voices  out  1  one-cycle strobe; controller_values is valid
note_values  out  16  bit 15 key_on; bit 14 = 0; bits 13:8 note index; bit 7 = 0; bits 6:0 velocity
controller_values  out  16  bit 15 = 0; bits 14:8 controller number; bit 7 = 0; bits 6:0 value
overflow  out  1  sticky; set when an event was dropped because the FIFO was full
fifo_empty  out  1  no pending events

Behaviour:
- Reset (reset=0, asynchronous):
  - Parser returns to IDLE; running status is cleared; FIFO is emptied.
  - All outputs = 0, except fifo_empty = 1.
  - Reset asserted mid-message discards the partial message.
- Parser states:
  - IDLE: no valid status is held.
  - WAIT_D1: waiting for the first data byte.
  - WAIT_D2: waiting for the second data byte.
  - SYSEX: discarding bytes until 0xF7.
- Byte classes:
  - 0xF8-0xFF (realtime): ignored in every state; no state or data change.
  - 0x80-0xEF (channel status): latched as running status; go to WAIT_D1. This also aborts any partial message.
  - 0xF0: go to SYSEX and clear running status.
  - 0xF1, 0xF3: one data byte, discarded; running status cleared.
  - 0xF2: two data bytes, discarded; running status cleared.
  - 0xF4-0xF7 outside SYSEX: go to IDLE; running status cleared.
  - In SYSEX, every byte except realtime bytes and 0xF7 is discarded. 0xF7 returns to IDLE.
- Data bytes (bit 7 = 0):
  - Messages 8n, 9n, An, Bn, En take two data bytes. Cn and Dn take one.
  - After a message completes, the parser returns to WAIT_D1 under running status.
  - A data byte received in IDLE is dropped.
- Channel filter: a completed message whose channel differs from CHANNEL produces no event.
- Event generation, on the edge that samples the completing byte:
  - 9n with velocity > 0: voice event, key_on = 1, index = note - NOTE_BASE, velocity = d2.
  - 8n, or 9n with velocity 0: voice event, key_on = 0, index as above, velocity = d2 (0 for 9n).
  - Note outside [NOTE_BASE, NOTE_BASE+63]: dropped silently; overflow is not set.
  - Bn: all-voices event, controller = d1, value = d2.
  - An, Cn, Dn, En: parsed for length, then dropped.
- FIFO: each entry is 17 bits, {type, payload16}.
  - A push when full is dropped and sets overflow.
  - A push and a pop on the same edge while full are both accepted.
  - Pointers wrap modulo FIFO_DEPTH.
- Output stage:
  - On each edge where the FIFO is not empty and generate_next = 0, pop one entry.
  - The matching strobe is high for exactly the following cycle.
  - note_values or controller_values is updated from the entry and holds until the next event of that type.
  - At most one strobe per cycle; the other strobe is 0.
- Latency: completing byte sampled at edge k, FIFO empty, generate_next low at k+1 → strobe high between edges k+1 and k+2.
- Throughput: one event per cycle while generate_next stays low.

Optional Feature:
- MIDI_OMNI_EN:
  - Defined: the channel filter is bypassed and all 16 channels generate events. CHANNEL is ignored.
  - Undefined: only CHANNEL is accepted.

Decomposition:
- Shared package midi_pkg:
  - parser state enum;
  - status nibble constants (NOTE_OFF=8, NOTE_ON=9, POLY_AT=A, CC=B, PROG=C, CH_AT=D, PITCH=E);
  - SYSEX_START=0xF0 and SYSEX_END=0xF7;
  - event-type constants EV_VOICE=0 and EV_ALL=1;
  - field offsets of note_values and controller_values.
- Sub-module midi_event_fifo: parameterised width/depth synchronous FIFO with full/empty; the same reset as this block.

Test Plan:
- 90 3C 64, NOTE_BASE=36, generate_next=0 → update_voice for one cycle, 2 cycles after the last byte; note_values = 0x9864.
- 90 3C 64 then 3E 00 (running status) → second update_voice with note_values = 0x1A00.
- B0 40 7F with FE inserted between 40 and 7F → one update_all_voices with controller_values = 0x407F; the realtime byte has no effect.
- F0 12 34 F7 then 45 10 → no events; the data bytes after the SysEx are dropped because running status is cleared. 91 3C 64 with CHANNEL=0 and MIDI_OMNI_EN undefined → no event; with MIDI_OMNI_EN defined → event.
- generate_next held high while 5 note-ons arrive, FIFO_DEPTH=4 → 4 events queued and overflow=1. When generate_next drops, 4 consecutive update_voice strobes in FIFO order, then fifo_empty=1.
- reset pulsed low after 90 3C → outputs 0, fifo_empty=1; a following 64 produces no event.
